// File: rtl/addsub_selftest_4bit.sv
// Self-test engine for a 4-bit adder-subtractor: walks all 512 {sel,a,b} vectors and checks each
// response against a built-in golden model. Optional ADDSUB_STOP_ON_FAIL_EN ends the run at the first mismatch.
module addsub_selftest_4bit #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       sel_out,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  input  logic       overflow_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       fail_valid,
  output logic [8:0] fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [8:0] IDX_LAST = 9'd511;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [8:0]       fail_vec_q, fail_vec_d;

  logic [3:0] gold_a;
  logic [3:0] gold_b;
  logic [4:0] gold_res;
  logic       gold_ov;
  logic       mismatch;
  logic       stop_run;

  // Golden model evaluated on the vector currently being driven out.
  always_comb begin
    gold_a = idx_q[7:4];
    gold_b = idx_q[3:0];
    if (idx_q[8]) begin
      gold_res = {1'b0, gold_a} + {1'b0, ~gold_b} + 5'd1;
      gold_ov  = (gold_a[3] != gold_b[3]) && (gold_res[3] != gold_a[3]);
    end else begin
      gold_res = {1'b0, gold_a} + {1'b0, gold_b};
      gold_ov  = (gold_a[3] == gold_b[3]) && (gold_res[3] != gold_a[3]);
    end
    mismatch = (sum_in != gold_res[3:0]) || (carry_in != gold_res[4]) ||
               (overflow_in != gold_ov);
  end

`ifdef ADDSUB_STOP_ON_FAIL_EN
  assign stop_run = mismatch;
`else
  assign stop_run = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = SETTLE;
          idx_d        = 9'd0;
          cnt_d        = CNT_RELOAD;
          err_d        = 10'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 9'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 10'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = idx_q;
          end
        end
        // Terminal test on 511 so the 9-bit index never wraps back to vector 0.
        if ((idx_q == IDX_LAST) || stop_run) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 9'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 9'd0;
      cnt_q        <= '0;
      err_q        <= 10'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 9'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign a_out      = idx_q[7:4];
  assign b_out      = idx_q[3:0];
  assign sel_out    = idx_q[8];
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == 10'd0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_addsub_selftest_4bit.sv
// Bench for addsub_selftest_4bit: a signed-arithmetic adder model with selectable faults feeds the
// checker; per-run expectations are queued at start and compared when done rises.
module tb_addsub_selftest_4bit;

  localparam int SETTLE = 2;
  localparam int FULL_EDGES = 512 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a_out, b_out;
  logic       sel_out;
  logic [3:0] sum_in;
  logic       carry_in, overflow_in;
  logic       busy, done, pass;
  logic [9:0] err_count;
  logic       fail_valid;
  logic [8:0] fail_vec;

  int n_checks = 0;
  int n_errors = 0;
  int fault_mode = 0;

  typedef struct {
    int err;
    int fv;
    int vec;
    int pass_e;
    int edges;
    int last_idx;
  } exp_t;
  exp_t exp_q[$];

  addsub_selftest_4bit #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_out(a_out), .b_out(b_out), .sel_out(sel_out),
    .sum_in(sum_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Reference adder written in signed-range terms, with planted faults per fault_mode.
  int sa, sb, r;
  logic [3:0] sum_m;
  logic carry_m, ov_m;
  always_comb begin
    sa = int'($signed(a_out));
    sb = int'($signed(b_out));
    if (sel_out) begin
      r = sa - sb;
      carry_m = (a_out >= b_out);
    end else begin
      r = sa + sb;
      carry_m = ((int'(a_out) + int'(b_out)) > 15);
    end
    ov_m  = (r > 7) || (r < -8);
    sum_m = r[3:0];
    if (fault_mode == 1) sum_m[0] = 1'b0;
    if (fault_mode == 2 && {sel_out, a_out, b_out} == 9'h071) ov_m = ~ov_m;
    if (fault_mode == 3 && {sel_out, a_out, b_out} == 9'h181) ov_m = ~ov_m;
  end
  assign sum_in      = sum_m;
  assign carry_in    = carry_m;
  assign overflow_in = ov_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 32'(a_out), 0);
    check({tag, "_b"}, 32'(b_out), 0);
    check({tag, "_sel"}, 32'(sel_out), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_fv"}, 32'(fail_valid), 0);
    check({tag, "_fvec"}, 32'(fail_vec), 0);
  endtask

  function automatic exp_t expect_for(input int mode);
    exp_t e;
    bit stop;
`ifdef ADDSUB_STOP_ON_FAIL_EN
    stop = 1'b1;
`else
    stop = 1'b0;
`endif
    case (mode)
      1: e.vec = 9'h001;
      2: e.vec = 9'h071;
      3: e.vec = 9'h181;
      default: e.vec = 0;
    endcase
    e.fv     = (mode != 0) ? 1 : 0;
    e.err    = (mode == 0) ? 0 : ((mode == 1 && !stop) ? 256 : 1);
    e.pass_e = (mode == 0) ? 1 : 0;
    if (stop && mode != 0) begin
      e.edges    = (SETTLE + 1) * (e.vec + 1);
      e.last_idx = e.vec;
    end else begin
      e.edges    = FULL_EDGES;
      e.last_idx = 511;
    end
    return e;
  endfunction

  // Pulse start; on return the edge that sampled it (edge 0) has passed.
  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 1);
    check({tag, "_done0"}, 32'(done), 0);
    check({tag, "_err0"}, 32'(err_count), 0);
    check({tag, "_fv0"}, 32'(fail_valid), 0);
  endtask

  task automatic run(input string tag, input int mode, input bit poke);
    int n;
    exp_t e;
    fault_mode = mode;
    exp_q.push_back(expect_for(mode));
    pulse_start(tag);
    n = 0;
    while (!done && n < FULL_EDGES + 200) begin
      start = (poke && (n % 97 == 40)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_edge"}, 32'(n), 32'(e.edges));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pass"}, 32'(pass), 32'(e.pass_e));
    check({tag, "_err"}, 32'(err_count), 32'(e.err));
    check({tag, "_fv"}, 32'(fail_valid), 32'(e.fv));
    check({tag, "_fvec"}, 32'(fail_vec), 32'(e.vec));
    check({tag, "_idx"}, 32'({sel_out, a_out, b_out}), 32'(e.last_idx));
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, 32'({done, err_count}), 32'({1'b1, 10'(e.err)}));
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_idle("reset");
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Reset asserted between edges must clear outputs without a clock.
    fault_mode = 1;
    pulse_start("t1");
    repeat (50) @(negedge clk);
    check("t1_pre_fv", 32'(fail_valid), 1);
    #2 reset = 1'b1;
    #1 check_idle("t1_async");
    @(negedge clk) reset = 1'b0;

    run("t2", 0, 1'b0);
    run("t3", 1, 1'b0);
    // Restart from DONE after a failing run, with start pokes while busy.
    run("t6", 0, 1'b1);
    run("t4", 2, 1'b0);
    run("t4b", 3, 1'b0);

    // Reset mid-run near edge 700, then a fresh complete run.
    fault_mode = 0;
    pulse_start("t5");
    k = 0;
    while (k < 700) begin
      @(negedge clk);
      k++;
    end
    check("t5_busy_pre", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 check_idle("t5_abort");
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_idle("t5_idle");
    run("t5_rerun", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
